div_arbiter: RTL and testbench

- Shares the single combinational `divider` (32/32 -> 16-bit Q7.8 result) between N_REQ requesters.
- Round-robin arbitration; registers the winner's operands and holds them stable for DIV_CYCLES cycles, so the divider runs as a multicycle path.
- Returns the captured result to the winner as a one-cycle one-hot response.
- Sits between the processor lanes and the divider instance.

---
 rtl/div_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/div_arbiter.sv | 122 ++++++++++++
 tb/tb_div_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// Shared types and widths for the divider arbiter and its round-robin picker.
package div_arb_pkg;

    localparam int OP_W  = 32;
    localparam int RES_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } div_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W:0] pos;

    // Scan from farthest to nearest so the position closest to ptr wins last.
    always_comb begin
        found = 1'b0;
        index = '0;
        pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(N_REQ)) begin
                pos = pos - (IDX_W + 1)'(N_REQ);
            end
            if (req[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                index = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one multicycle divider between N_REQ requesters.
// Optional macro DIV_ARB_ZERO_BYPASS_EN: zero denominators skip the wait and respond with 0.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int DIV_CYCLES = 4,
    localparam int IDX_W      = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*OP_W-1:0]  req_num,
    input  logic [N_REQ*OP_W-1:0]  req_den,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [RES_W-1:0]       rsp_result,
    output logic [OP_W-1:0]        div_numerator,
    output logic [OP_W-1:0]        div_denominator,
    input  logic [RES_W-1:0]       div_result_q78,
    output logic                   busy,
    output logic [IDX_W-1:0]       grant_id
);

    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    div_arb_state_t   state_reg, state_next;
    logic [IDX_W-1:0] rr_ptr_reg, grant_reg, winner, rr_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic [OP_W-1:0]  num_reg, den_reg;
    logic [RES_W-1:0] result_reg;
    logic             found, accept, zero_skip;
    logic [OP_W-1:0]  num_slice [N_REQ];
    logic [OP_W-1:0]  den_slice [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign num_slice[gi] = req_num[OP_W*gi +: OP_W];
            assign den_slice[gi] = req_den[OP_W*gi +: OP_W];
        end
    endgenerate

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .found (found),
        .index (winner)
    );

    assign accept      = (state_reg == IDLE) && found && !rst;
    assign rr_ptr_next = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);

`ifdef DIV_ARB_ZERO_BYPASS_EN
    assign zero_skip = (den_slice[winner] == '0);
`else
    assign zero_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = zero_skip ? RESP : WAIT;
            WAIT:    if (count_reg == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands stay frozen from accept until the next accept: the divider path is multicycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
            grant_reg  <= '0;
            count_reg  <= '0;
            num_reg    <= '0;
            den_reg    <= '0;
            result_reg <= '0;
        end else if (accept) begin
            num_reg    <= num_slice[winner];
            den_reg    <= den_slice[winner];
            grant_reg  <= winner;
            rr_ptr_reg <= rr_ptr_next;
            count_reg  <= CNT_W'(DIV_CYCLES - 1);
            if (zero_skip) begin
                result_reg <= '0;
            end
        end else if (state_reg == WAIT) begin
            if (count_reg == '0) begin
                result_reg <= div_result_q78;
            end else begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
        if (state_reg == RESP) begin
            rsp_valid[grant_reg] = 1'b1;
        end
        busy = (state_reg != IDLE);
    end

    assign rsp_result      = result_reg;
    assign div_numerator   = num_reg;
    assign div_denominator = den_reg;
    assign grant_id        = grant_reg;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural divider returning {quotient[7:0], remainder[7:0]}.
module tb_div_arbiter;

    localparam int N  = 4;
    localparam int DC = 4;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    localparam int LAT_Z = 1;
`else
    localparam int LAT_Z = DC + 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*32-1:0] req_num, req_den;
    logic [N-1:0]  rsp_valid;
    logic [15:0]   rsp_result;
    logic [31:0]   div_numerator, div_denominator;
    logic [15:0]   div_result_q78;
    logic          busy;
    logic [1:0]    grant_id;

    logic [31:0]   nums [N];
    logic [31:0]   dens [N];
    logic [31:0]   quo, rem;
    logic [15:0]   exp_res [N];

    int checks = 0;
    int errors = 0;

    div_arbiter #(.N_REQ(N), .DIV_CYCLES(DC)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_num         (req_num),
        .req_den         (req_den),
        .rsp_valid       (rsp_valid),
        .rsp_result      (rsp_result),
        .div_numerator   (div_numerator),
        .div_denominator (div_denominator),
        .div_result_q78  (div_result_q78),
        .busy            (busy),
        .grant_id        (grant_id)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_num = '0;
        req_den = '0;
        for (int i = 0; i < N; i++) begin
            req_num[32*i +: 32] = nums[i];
            req_den[32*i +: 32] = dens[i];
        end
    end

    always_comb begin
        quo = '0;
        rem = '0;
        div_result_q78 = '0;
        if (div_denominator != '0) begin
            quo = div_numerator / div_denominator;
            rem = div_numerator % div_denominator;
            div_result_q78 = {quo[7:0], rem[7:0]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller has set req_valid/operands at a falling edge; accept happens at the next rising edge.
    task automatic serve(input int g, input logic [15:0] exp, input int lat, input bit drop);
        logic [N-1:0] oh;
        oh = N'(1) << g;
        #1;
        chk("ready_accept", 32'(req_ready), 32'(oh));
        @(negedge clk);
        if (drop) req_valid[g] = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            chk("busy", 32'(busy), 32'd1);
            chk("ready_busy", 32'(req_ready), 32'd0);
            chk("rsp_valid", 32'(rsp_valid), (k == lat) ? 32'(oh) : 32'd0);
            chk("num_held", div_numerator, nums[g]);
            chk("den_held", div_denominator, dens[g]);
            if (k == lat) begin
                chk("rsp_result", 32'(rsp_result), 32'(exp));
                chk("grant_id", 32'(grant_id), 32'(g));
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_reset_outputs;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_num", div_numerator, 32'd0);
        chk("rst_den", div_denominator, 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            nums[i] = '0;
            dens[i] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;

        // Single op: 100/4 -> 0x1900, response in cycle 5
        nums[0] = 32'd100; dens[0] = 32'd4;
        req_valid = 4'b0001;
        serve(0, 16'h1900, DC + 1, 1'b1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("result_hold", 32'(rsp_result), 32'h1900);

        // Remainder case: 7/2 -> 0x0301
        nums[2] = 32'd7; dens[2] = 32'd2;
        req_valid = 4'b0100;
        serve(2, 16'h0301, DC + 1, 1'b1);

        // Contention from reset: grants 0,1,2,3,0 spaced DC+2 apart
        rst = 1'b1;
        nums[0] = 32'd100; dens[0] = 32'd4;  exp_res[0] = 16'h1900;
        nums[1] = 32'd50;  dens[1] = 32'd7;  exp_res[1] = 16'h0701;
        nums[2] = 32'd7;   dens[2] = 32'd2;  exp_res[2] = 16'h0301;
        nums[3] = 32'd255; dens[3] = 32'd16; exp_res[3] = 16'h0F0F;
        req_valid = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            serve(n % N, exp_res[n % N], DC + 1, 1'b0);
        end
        req_valid = '0;

        // Fairness: after 1 is served, 0 and 3 pending -> 3 before 0
        req_valid = 4'b0010;
        serve(1, exp_res[1], DC + 1, 1'b1);
        req_valid = 4'b1001;
        serve(3, exp_res[3], DC + 1, 1'b1);
        serve(0, exp_res[0], DC + 1, 1'b1);

        // Zero denominator
        nums[1] = 32'd5; dens[1] = 32'd0;
        req_valid = 4'b0010;
        serve(1, 16'h0000, LAT_Z, 1'b1);

        // Reset during WAIT aborts the op; pending request 0 wins right after reset
        nums[2] = 32'd7; dens[2] = 32'd2;
        req_valid = 4'b0100;
        #1;
        chk("abort_ready", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        nums[0] = 32'd9; dens[0] = 32'd3;
        req_valid = 4'b0001;
        #1;
        chk("ready_in_rst", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;
        serve(0, 16'h0300, DC + 1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
